div_scheduler: RTL
==================

Name: div_scheduler

Overview:
- Shares one pipelined divider core (dividend/divisor in, quotient/remainder out, start/valid strobes) between NUM_REQ requesters in the gain-control datapath.
- Arbitrates requests round-robin and issues them to the divider.
- Tags each issue in an in-order tag FIFO and routes each returning result to the requester that issued it.

Parameters:
- DATA_SIZE, 10, width of dividend, divisor and quotient.
- REMAINDER_SIZE, 8, width of the fractional remainder.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 4, tag FIFO depth, i.e. maximum number of divisions in flight (power of two, ≥2).

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_dividend  in  NUM_REQ*DATA_SIZE  flattened dividends; requester k occupies bits [k*DATA_SIZE +: DATA_SIZE].
- i_req_divisor  in  NUM_REQ*DATA_SIZE  flattened divisors, same packing.
- o_req_ready  out  NUM_REQ  one-hot grant; a handshake occurs on valid&ready.
- o_div_start  out  1  start strobe to the divider.
- o_div_dividend  out  DATA_SIZE  operand to the divider.
- o_div_divisor  out  DATA_SIZE  operand to the divider.
- i_div_valid  in  1  divider result strobe.
- i_div_quotient  in  DATA_SIZE  divider quotient.
- i_div_remainder  in  REMAINDER_SIZE  divider remainder.
- o_resp_valid  out  NUM_REQ  one-hot result strobe.
- o_resp_quotient  out  DATA_SIZE  result bus shared by all requesters.
- o_resp_remainder  out  REMAINDER_SIZE  result bus shared by all requesters.
- o_busy  out  1  high while outstanding count > 0.
- o_orphan_err  out  1  sticky; a result arrived with no outstanding tag.

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge) clears:
  - all outputs to 0;
  - round-robin pointer to 0;
  - tag FIFO read/write pointers;
  - outstanding count.
- Reset mid-operation discards every in-flight tag. The divider is reset by the same reset.
- Grant (combinational):
  - Condition: outstanding count + pending issue < MAX_OUTSTANDING and not in reset.
  - o_req_ready is asserted for the first requester with valid=1, searching upward from the round-robin pointer with wrap-around at NUM_REQ-1 → 0.
  - Never more than one ready bit is set.
  - No grant is given while the FIFO is full.
- After a handshake with requester k:
  - The round-robin pointer becomes (k+1) mod NUM_REQ.
  - Operands are registered.
  - o_div_start pulses for exactly one cycle on the next cycle, carrying k's operands.
  - Tag k is pushed to the FIFO in that same cycle.
- Issue rate: at most one issue per cycle; back-to-back issues are allowed.
- Requester contract: each requester holds valid and its operands until it receives ready.
- On i_div_valid=1 with the FIFO non-empty:
  - Pop the tag t.
  - On the next cycle, o_resp_valid[t]=1 for one cycle, with quotient/remainder registered from the divider.
  - Responses have no backpressure; requesters must accept them.
- On i_div_valid=1 with the FIFO empty: the result is dropped and o_orphan_err is set; it clears only on reset.
- Push and pop in the same cycle leave the outstanding count unchanged. Full and empty flags derive from pointers with an extra wrap bit.
- End-to-end latency: handshake → start +1 cycle; divider valid → response +1 cycle. Results are returned strictly in issue order.
- Arithmetic: operands pass through unmodified, signed two's complement. Quotient and remainder are not interpreted.

Optional Feature:
- Macro DIV_SCHED_ZERO_FLAG_EN.
- Defined:
  - Adds output o_resp_div_zero (1 bit).
  - The tag FIFO stores an extra bit, (divisor==0), computed at issue.
  - o_resp_div_zero is driven with o_resp_valid and is 0 otherwise. Reset value is 0.
  - The request is still issued to the divider.
- Undefined: the port and the FIFO bit are absent. Behaviour is otherwise identical.

Decomposition:
- Package div_sched_pkg holds:
  - the tag width function clog2(NUM_REQ);
  - the FIFO entry typedef (tag plus optional zero bit);
  - the round-robin next-pointer function.
- One sub-module, div_tag_fifo: a synchronous FIFO, depth MAX_OUTSTANDING, with full/empty/count.
- The arbiter and response routing stay in div_scheduler.

Test Plan:
- Single request: requester 2 issues 100/7 → ready[2] asserted for one cycle. Next cycle o_div_start=1 with operands 100 and 7. When the model divider returns q=14, o_resp_valid=4'b0100 one cycle later with q=14.
- Fairness: all 4 requesters hold valid continuously → grants follow the order 0,1,2,3,0,1, with no requester granted twice before every other valid requester has been granted.
- Full limit: the model divider is stalled and 6 requests are pending → exactly 4 starts, ready held low. Releasing one result allows exactly one new issue.
- Simultaneous push/pop: an issue and a return in the same cycle → o_busy stays 1, the count is unchanged, and the next result is routed to the correct tag.
- Orphan and reset: i_div_valid pulsed with the FIFO empty → o_orphan_err=1 and no resp_valid. i_reset asserted with 3 requests in flight → all outputs 0 next cycle and o_busy=0.
- With DIV_SCHED_ZERO_FLAG_EN: requester 1 issues 50/0 → its response carries o_resp_div_zero=1. A following 50/5 carries 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and helpers for the divider scheduler.
// Optional feature macro: DIV_SCHED_ZERO_FLAG_EN adds a divide-by-zero bit
// to each tag FIFO entry.

package div_sched_pkg;

  // Widest tag ever needed (NUM_REQ is at most 8).
  localparam int TAG_W_MAX = 3;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Tag width for a given requester count; never narrower than one bit.
  function automatic int tag_width(input int num_req);
    return (num_req <= 2) ? 1 : clog2(num_req);
  endfunction

  // Round-robin pointer after a grant to requester k.
  function automatic int rr_next(input int k, input int num_req);
    return (k >= num_req - 1) ? 0 : k + 1;
  endfunction

  // One in-flight division: who issued it and, optionally, whether the
  // divisor was zero at issue time.
  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
`ifdef DIV_SCHED_ZERO_FLAG_EN
    logic                 div_zero;
`endif
  } tag_entry_t;

endpackage

// File: rtl/div_tag_fifo.sv
// div_tag_fifo: in-order tag FIFO recording which requester owns each
// division in flight. Pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter.

import div_sched_pkg::*;

module div_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_pop_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_count
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset discards every stored tag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clock) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: shares one pipelined divider between NUM_REQ requesters.
// Round-robin grant, one registered issue per cycle, in-order tag FIFO to
// route each returning result to its requester.
// Optional feature macro: DIV_SCHED_ZERO_FLAG_EN adds o_resp_div_zero.

import div_sched_pkg::*;

module div_scheduler #(
  parameter int DATA_SIZE       = 10,
  parameter int REMAINDER_SIZE  = 8,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   i_req_dividend,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   i_req_divisor,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_div_start,
  output logic [DATA_SIZE-1:0]           o_div_dividend,
  output logic [DATA_SIZE-1:0]           o_div_divisor,
  input  logic                           i_div_valid,
  input  logic [DATA_SIZE-1:0]           i_div_quotient,
  input  logic [REMAINDER_SIZE-1:0]      i_div_remainder,
  output logic [NUM_REQ-1:0]             o_resp_valid,
  output logic [DATA_SIZE-1:0]           o_resp_quotient,
  output logic [REMAINDER_SIZE-1:0]      o_resp_remainder,
  output logic                           o_busy,
  output logic                           o_orphan_err
`ifdef DIV_SCHED_ZERO_FLAG_EN
  ,
  output logic                           o_resp_div_zero
`endif
);

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;

  logic [TAG_W-1:0]          r_rr_ptr;
  logic [TAG_W-1:0]          w_grant_idx;
  logic                      w_grant_found;
  logic                      w_can_issue;
  logic                      w_handshake;
  logic [NUM_REQ-1:0]        w_ready;
  logic [DATA_SIZE-1:0]      w_sel_dividend;
  logic [DATA_SIZE-1:0]      w_sel_divisor;
  logic [CNT_W-1:0]          w_inflight;

  logic                      r_div_start;
  logic [DATA_SIZE-1:0]      r_div_dividend;
  logic [DATA_SIZE-1:0]      r_div_divisor;
  tag_entry_t                r_issue_entry;

  tag_entry_t                w_head_entry;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [CNT_W-1:0]          w_fifo_count;
  logic                      w_pop;
  logic [NUM_REQ-1:0]        w_resp_onehot;

  logic [NUM_REQ-1:0]        r_resp_valid;
  logic [DATA_SIZE-1:0]      r_resp_quotient;
  logic [REMAINDER_SIZE-1:0] r_resp_remainder;
  logic                      r_orphan_err;
`ifdef DIV_SCHED_ZERO_FLAG_EN
  logic                      r_resp_div_zero;
`endif

  // A registered-but-not-yet-pushed issue still occupies a FIFO slot.
  assign w_inflight  = w_fifo_count + CNT_W'(r_div_start);
  assign w_can_issue = !i_reset && !w_fifo_full &&
                       (w_inflight < CNT_W'(MAX_OUTSTANDING));
  assign w_handshake = w_can_issue && w_grant_found;

  // Search upward from the round-robin pointer for the first valid request.
  always_comb begin
    int j;
    j             = 0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_grant_found && i_req_valid[TAG_W'(j)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = TAG_W'(j);
      end
    end
  end

  // One-hot ready for the winning requester only.
  always_comb begin
    w_ready = '0;
    if (w_handshake) w_ready[w_grant_idx] = 1'b1;
  end

  assign o_req_ready    = w_ready;
  assign w_sel_dividend = i_req_dividend[w_grant_idx*DATA_SIZE +: DATA_SIZE];
  assign w_sel_divisor  = i_req_divisor[w_grant_idx*DATA_SIZE +: DATA_SIZE];

  // Register the granted operands and tag; start pulses on the next cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div_start    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_issue_entry  <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_div_start <= w_handshake;
      if (w_handshake) begin
        r_div_dividend         <= w_sel_dividend;
        r_div_divisor          <= w_sel_divisor;
        r_issue_entry.tag      <= TAG_W_MAX'(w_grant_idx);
`ifdef DIV_SCHED_ZERO_FLAG_EN
        r_issue_entry.div_zero <= (w_sel_divisor == '0);
`endif
        r_rr_ptr               <= TAG_W'(rr_next(int'(w_grant_idx), NUM_REQ));
      end
    end
  end

  assign o_div_start    = r_div_start;
  assign o_div_dividend = r_div_dividend;
  assign o_div_divisor  = r_div_divisor;

  // The tag is pushed in the same cycle the divider sees start.
  div_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(tag_entry_t))
  ) u_tag_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (r_div_start),
    .i_push_data (r_issue_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_entry),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign w_pop  = i_div_valid && !w_fifo_empty;
  assign o_busy = !w_fifo_empty;

  // Decode the head tag into the requester's response strobe.
  always_comb begin
    w_resp_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_resp_onehot[k] = (w_head_entry.tag == TAG_W_MAX'(k));
    end
  end

  // Register the returning result toward its owner; flag results with no owner.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_resp_valid     <= '0;
      r_resp_quotient  <= '0;
      r_resp_remainder <= '0;
      r_orphan_err     <= 1'b0;
`ifdef DIV_SCHED_ZERO_FLAG_EN
      r_resp_div_zero  <= 1'b0;
`endif
    end else begin
      r_resp_valid <= '0;
`ifdef DIV_SCHED_ZERO_FLAG_EN
      r_resp_div_zero <= 1'b0;
`endif
      if (w_pop) begin
        r_resp_valid     <= w_resp_onehot;
        r_resp_quotient  <= i_div_quotient;
        r_resp_remainder <= i_div_remainder;
`ifdef DIV_SCHED_ZERO_FLAG_EN
        r_resp_div_zero  <= w_head_entry.div_zero;
`endif
      end else if (i_div_valid) begin
        r_orphan_err <= 1'b1;
      end
    end
  end

  assign o_resp_valid     = r_resp_valid;
  assign o_resp_quotient  = r_resp_quotient;
  assign o_resp_remainder = r_resp_remainder;
  assign o_orphan_err     = r_orphan_err;
`ifdef DIV_SCHED_ZERO_FLAG_EN
  assign o_resp_div_zero  = r_resp_div_zero;
`endif

endmodule
